fft_loader: RTL
===============

# fft_loader

Input stage of the FFT datapath. Accepts a stream of real samples over a valid/ready handshake and writes one 2^N_LOG2-point frame into the FFT working RAM. Each sample is sign-extended to `width` bits, the imaginary part is zeroed, and the write address is bit-reversed. It then pulses `start` to the `fft` core and holds off further input until the core reports `done`.

## Interface
- `width`, default 16: complex word half-width. The RAM word is 2*width bits, `{re, im}`.
- `N_LOG2`, default 11: log2 of the frame length. 11 gives 2048 points.
- `clk`  in  1: single clock. All logic is rising-edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `sample_valid`  in  1: upstream has a sample on `sample_in`.
- `sample_in`  in  width-5: signed two's-complement real sample. The 5-bit headroom absorbs FFT bit growth.
- `sample_ready`  out  1: loader can accept a sample this cycle.
- `we`  out  1: RAM write enable, registered.
- `adr`  out  N_LOG2: RAM write address, registered.
- `wd`  out  2*width: RAM write data, registered, `{sext(sample_in), width'b0}`.
- `start`  out  1: one-cycle pulse to the FFT core.
- `done`  in  1: FFT core completion. Pulse or level.
- `busy`  out  1: high in FLUSH, START and WAIT.
- `frames`  out  16: count of frames handed to the core. Wraps at 2^16.

## Operation
- States are LOAD, FLUSH, START and WAIT. The reset state is LOAD.
- On reset, `cnt`=0, `frames`=0, `we`=0, `adr`=0, `wd`=0, `start`=0, `busy`=0, and `sample_ready`=1.
- `sample_ready` = (state==LOAD). It is a decode of registered state only, with no combinational path from `sample_valid`.
- A handshake occurs when `sample_valid` && `sample_ready` are both high. A `sample_valid` with no `sample_ready` is held by upstream, never dropped.
- **LOAD:**
  - On each handshake, register `we`=1, `adr`=bitrev(`cnt`), `wd`={sign-extended `sample_in`, 0}, then `cnt`++.
  - If no handshake occurs, `we`=0.
  - If the handshake has `cnt`==2^N_LOG2−1, `cnt` wraps to 0 and the state moves to FLUSH.
- **FLUSH:** lasts one cycle. The final write is presented on `we`/`adr`/`wd` during this cycle. Next state is START.
- **START:** `start`=1 for exactly this cycle and `we`=0. `frames`++ at the end of the cycle. Next state is WAIT.
- **WAIT:** `we`=0. When `done`=1 is sampled, the next state is LOAD.
- `done` is ignored in LOAD, FLUSH and START. A `done` left over from the previous frame cannot release WAIT early, because WAIT is entered after `start`.
- `we` is only ever asserted for exactly one cycle per accepted sample. Each frame produces 2^N_LOG2 writes with distinct addresses.
- Arithmetic rules:
  - Sign extension replicates `sample_in[width-6]` into bits [width-1:width-5].
  - Bit reversal maps address bit i to bit N_LOG2−1−i.
- If reset asserts mid-frame, the partial frame is abandoned. No `start` is issued and `cnt` restarts at 0.

## Timing
- Handshake in cycle k produces `we`/`adr`/`wd` valid in cycle k+1, so write latency is 1 cycle.
- The last handshake in cycle k gives FLUSH at k+1 (last write), START at k+2 (`start`=1), and WAIT from k+3.
- `sample_ready` falls in cycle k+1.
- `done` sampled high in cycle m gives LOAD and `sample_ready`=1 in cycle m+1.
- Peak throughput is one sample per cycle. Minimum frame overhead is 3 cycles plus FFT time.
- `busy` and `frames` are registered.

## Configuration
- `FFT_LOADER_BITREV_EN`:
  - Defined: `adr`=bitrev(`cnt`), which is the ordering required by the in-place decimation-in-time core.
  - Undefined: `adr`=`cnt` (natural order), for cores that reorder internally.
- All other behaviour is identical with or without the macro.

## Test plan
- **Reset:** assert `reset_n`=0 mid-LOAD with `cnt`=5 → outputs immediately `we`=0, `start`=0, `frames`=0, `sample_ready`=1. After release, the first write goes to `adr`=0.
- **Full frame, N_LOG2=3, BITREV_EN defined:** feed samples 0..7 back-to-back → `adr` sequence 0,4,2,6,1,5,3,7, and `start` pulses exactly 2 cycles after the 8th handshake.
- **Sign extension, width=16:** `sample_in`=11'h7FF (−1) → `wd`=32'hFFFF_0000. `sample_in`=11'h3FF → `wd`=32'h03FF_0000.
- **Backpressure:** hold `sample_valid`=1 through WAIT for 20 cycles → no `we`, `sample_ready`=0, and `cnt` unchanged. Pulse `done` → `sample_ready`=1 next cycle and the frame restarts at `adr`=0.
- **Gapped input:** toggle `sample_valid` every other cycle → exactly 8 writes, `we` never high for two cycles for one sample, and `frames` goes 0→1.
- **Done outside WAIT:** hold `done`=1 during LOAD and START → ignored. The WAIT exit occurs only after `start`. With BITREV_EN undefined, `adr` runs 0..7 in order.

Source files
------------

// File: rtl/fft_loader.sv
// fft_loader: input stage of the FFT datapath.
// Collects one 2^N_LOG2-point frame of real samples over a valid/ready
// handshake, writes each into the FFT working RAM as {sext(re), 0}, then
// pulses start to the core and holds off new input until the core is done.
// Optional feature macro: FFT_LOADER_BITREV_EN
//   defined   -> write addresses are bit-reversed (in-place DIT core order)
//   undefined -> write addresses are in natural order
module fft_loader #(
    parameter int width  = 16,
    parameter int N_LOG2 = 11
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sample_valid,
    input  logic [width-6:0]      sample_in,
    output logic                  sample_ready,
    output logic                  we,
    output logic [N_LOG2-1:0]     adr,
    output logic [2*width-1:0]    wd,
    output logic                  start,
    input  logic                  done,
    output logic                  busy,
    output logic [15:0]           frames
);

    localparam logic [1:0] LOAD  = 2'd0;
    localparam logic [1:0] FLUSH = 2'd1;
    localparam logic [1:0] START = 2'd2;
    localparam logic [1:0] WAIT  = 2'd3;

    localparam logic [N_LOG2-1:0] CNT_LAST = '1;

    logic [1:0]        state;
    logic [1:0]        next_state;
    logic [N_LOG2-1:0] cnt;
    logic [N_LOG2-1:0] write_adr;
    logic              handshake;

    function automatic logic [N_LOG2-1:0] bit_reverse(input logic [N_LOG2-1:0] value);
        logic [N_LOG2-1:0] result;
        for (int i = 0; i < N_LOG2; i++) begin
            result[i] = value[N_LOG2-1-i];
        end
        return result;
    endfunction

`ifdef FFT_LOADER_BITREV_EN
    assign write_adr = bit_reverse(cnt);
`else
    assign write_adr = cnt;
`endif

    // Ready is a pure decode of registered state, so there is no
    // combinational path from sample_valid back to sample_ready.
    assign sample_ready = (state == LOAD);
    assign handshake    = sample_valid && sample_ready;

    // Frame sequencing: load all points, flush the last write, kick the
    // core, then wait for it; done only matters once start has been issued.
    always_comb begin
        next_state = state;
        case (state)
            LOAD:    if (handshake && (cnt == CNT_LAST)) next_state = FLUSH;
            FLUSH:   next_state = START;
            START:   next_state = WAIT;
            WAIT:    if (done) next_state = LOAD;
            default: next_state = LOAD;
        endcase
    end

    // State register; a reset abandons any partial frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= LOAD;
        else          state <= next_state;
    end

    // Sample index within the frame; wraps to 0 on the last point.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       cnt <= '0;
        else if (handshake) cnt <= cnt + 1'b1;
    end

    // RAM write port: one registered write per accepted sample, imaginary zeroed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we  <= 1'b0;
            adr <= '0;
            wd  <= '0;
        end else begin
            we <= handshake;
            if (handshake) begin
                adr <= write_adr;
                wd  <= {{5{sample_in[width-6]}}, sample_in, {width{1'b0}}};
            end
        end
    end

    // Core handshake outputs: single-cycle start, busy tracking the non-load states.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start <= 1'b0;
            busy  <= 1'b0;
        end else begin
            start <= (state == FLUSH);
            busy  <= (next_state != LOAD);
        end
    end

    // Frame counter advances as each frame is handed to the core.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)              frames <= '0;
        else if (state == START)   frames <= frames + 16'd1;
    end

endmodule
